// File: rtl/lsu_port.sv
`default_nettype none
// ============================================================================
// lsu_port : single-outstanding load/store port between a core and a
//            synchronous memory that returns sized, extended read data.
// Revision  : 1.0
// ============================================================================
module lsu_port #(
  parameter int STRICT_ALIGN = 0
) (
  input  logic        LSU_CLK,
  input  logic        LSU_RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  output logic [7:0]  ERR_CNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        r_mem_rden;
  logic        r_mem_we;
  logic [7:0]  r_err_cnt;

  logic        w_accept;
  logic        w_misaligned;

  assign w_accept = REQ_VALID && r_req_ready;

  // Misalignment is judged on the live request so a bad access never strobes memory.
  always_comb begin
    w_misaligned = 1'b0;
    case (REQ_SIZE)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = (REQ_ADDR[1:0] == 2'd3) ||
                              ((STRICT_ALIGN != 0) && REQ_ADDR[0]);
      2'd2:    w_misaligned = (REQ_ADDR[1:0] != 2'd0);
      default: w_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge LSU_CLK or negedge LSU_RST_N) begin
    if (!LSU_RST_N) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_size      <= 2'd0;
      r_sign      <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_mem_rden  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_err_cnt   <= 8'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= REQ_WE;
            r_addr      <= REQ_ADDR;
            r_wdata     <= REQ_WDATA;
            r_size      <= REQ_SIZE;
            r_sign      <= REQ_SIGN;
            r_req_ready <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= w_misaligned;
            if (w_misaligned) begin
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_mem_rden <= !REQ_WE;
              r_mem_we   <= REQ_WE;
              r_state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          r_mem_rden <= 1'b0;
          r_mem_we   <= 1'b0;
          if (r_we) begin
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_state <= DATA;
          end
        end
        DATA: begin
          r_rsp_rdata <= MEM_DOUT2;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;
  assign MEM_RDEN2 = r_mem_rden;
  assign MEM_WE2   = r_mem_we;
  assign MEM_ADDR2 = r_addr;
  assign MEM_DIN2  = r_wdata;
  assign MEM_SIZE  = r_size;
  assign MEM_SIGN  = r_sign;
  assign ERR_CNT   = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have parameter STRICT_ALIGN, default 0; 1 = halfword at odd byte offset is misaligned.
REQ-002 SHALL have ports: LSU_CLK in 1 clock; LSU_RST_N in 1 reset, asynchronous, active-low.
REQ-003 SHALL have core-side request ports: REQ_VALID in 1; REQ_READY out 1; REQ_WE in 1 (1 store, 0 load); REQ_ADDR in 32; REQ_WDATA in 32; REQ_SIZE in 2 (0 byte, 1 half, 2 word); REQ_SIGN in 1 (1 unsigned, 0 signed).
REQ-004 SHALL have core-side response ports: RSP_VALID out 1; RSP_READY in 1; RSP_RDATA out 32; RSP_ERR out 1.
REQ-005 SHALL have memory-side ports: MEM_RDEN2 out 1; MEM_WE2 out 1; MEM_ADDR2 out 32; MEM_DIN2 out 32; MEM_SIZE out 2; MEM_SIGN out 1; MEM_DOUT2 in 32 (sized and extended, valid one cycle after MEM_RDEN2 while address/size/sign are held).
REQ-006 SHALL have ERR_CNT out 8: saturating count of misaligned requests.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, DATA, RESP.
REQ-008 IDLE: REQ_READY=1; all other states REQ_READY=0.
REQ-009 On REQ_VALID&&REQ_READY, SHALL latch REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_SIGN into request registers.
REQ-010 Misaligned, evaluated on REQ_SIZE/REQ_ADDR[1:0] at accept: size 3; word with offset !=0; half with offset 3; half with offset 1 when STRICT_ALIGN=1.
REQ-011 Misaligned accept: IDLE->RESP with err flag set, RSP_RDATA=0, no memory strobe ever asserted, ERR_CNT+1 saturating at 255.
REQ-012 Aligned accept: IDLE->ACCESS.
REQ-013 ACCESS lasts exactly one cycle: MEM_RDEN2=1 for load, MEM_WE2=1 for store, never both; store -> RESP; load -> DATA.
REQ-014 DATA lasts exactly one cycle: MEM_RDEN2=0, MEM_WE2=0; MEM_ADDR2/MEM_SIZE/MEM_SIGN unchanged; MEM_DOUT2 captured into RSP_RDATA register at end of cycle; -> RESP.
REQ-015 MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN SHALL be driven directly from request registers in all states; MEM_DIN2 unshifted (byte/half data in low bits).
REQ-016 MEM_RDEN2 and MEM_WE2 SHALL be 0 in every state except ACCESS.
REQ-017 RESP: RSP_VALID=1; RSP_RDATA and RSP_ERR stable until RSP_READY sampled 1; then -> IDLE.
REQ-018 Store response: RSP_RDATA=0, RSP_ERR=0.
REQ-019 Latency accept-edge to RSP_VALID: load 3 cycles, store 2, misaligned 1; back-to-back throughput with RSP_READY=1: one request per 4 (load), 3 (store) or 2 (misaligned) cycles.
REQ-020 RSP_READY outside RESP SHALL be ignored; REQ_VALID outside IDLE SHALL be ignored (no latching).
REQ-021 Addresses >= 32'h00010000 (IO range) SHALL follow identical sequencing; no special-casing.

Reset
REQ-022 LSU_RST_N=0 SHALL immediately force: state IDLE, REQ_READY=1 (after release), RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_RDEN2=0, MEM_WE2=0, MEM_ADDR2=0, MEM_DIN2=0, MEM_SIZE=0, MEM_SIGN=0, ERR_CNT=0.
REQ-023 Reset during ACCESS, DATA or RESP SHALL abort the transaction with no response issued after release.

Verification
REQ-024 Store word 0xDEADBEEF @0x100, then load word @0x100 -> MEM_WE2 pulse 1 cycle, RSP 2 cycles after accept; load RSP_RDATA=0xDEADBEEF, RSP_ERR=0, 3 cycles after accept.
REQ-025 Signed byte load @0x103 with memory word 0x80FF0000 -> RSP_RDATA=0xFFFFFF80; unsigned -> 0x00000080; MEM_ADDR2 held =0x103 through DATA.
REQ-026 Load word @0x102, then half @0x103 -> two error responses at 1 cycle latency, no MEM_RDEN2/MEM_WE2 pulses, ERR_CNT=2; with STRICT_ALIGN=1 half @0x101 also errors.
REQ-027 Load with RSP_READY=0 for 5 cycles -> RSP_VALID and RSP_RDATA held stable, REQ_READY=0, new REQ_VALID ignored until handshake.
REQ-028 LSU_RST_N asserted during DATA of a load -> all outputs zero immediately, no RSP_VALID after release, next request completes normally.
REQ-029 256 misaligned requests -> ERR_CNT saturates at 255.
